// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall controller for a two-stage-after-fetch pipeline (IF -> EXE -> MWB).
// Stretches the pipe over slow data memory, inserts load-use bubbles and flushes on taken branches.
module pipe_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [4:0]  ex_rs1,
    input  logic [4:0]  ex_rs2,
    input  logic        br_taken,
    input  logic        mwb_valid,
    input  logic        mwb_load,
    input  logic        mwb_store,
    input  logic [4:0]  mwb_rd,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        hold_if,
    output logic        hold_mwb,
    output logic        bubble_mwb,
    output logic        flush_if,
    output logic        mem_err,
    output logic [15:0] stall_cnt
);

    // state    | meaning
    // RUN      | normal flow; single-cycle memory ops and branch flushes handled here
    // MEM_WAIT | memory access outstanding, whole pipe frozen
    // LD_USE   | one bubble cycle after a load feeding the EXE instruction
    // ERR      | memory timed out; pipe frozen until reset
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        LD_USE   = 2'd2,
        ERR      = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_TC = 8'(TIMEOUT);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  wait_cnt;
    logic [7:0]  wait_nxt;

    logic        mem_op;
    logic        ld_haz;
    logic        req_c;
    logic        hold_if_c;
    logic        hold_mwb_c;
    logic        bubble_c;
    logic        flush_c;
    logic        err_c;

    assign mem_op = mwb_valid & (mwb_load | mwb_store);
    assign ld_haz = mwb_valid & mwb_load & ex_valid & (mwb_rd != 5'd0) &
                    ((mwb_rd == ex_rs1) | (mwb_rd == ex_rs2));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        wait_nxt   = wait_cnt;
        req_c      = 1'b0;
        hold_if_c  = 1'b0;
        hold_mwb_c = 1'b0;
        bubble_c   = 1'b0;
        flush_c    = 1'b0;
        err_c      = 1'b0;
        case (state)
            RUN: begin
                req_c = mem_op;
                if (mem_op && !mem_ack) begin
                    hold_if_c  = 1'b1;
                    hold_mwb_c = 1'b1;
                    state_nxt  = MEM_WAIT;
                    wait_nxt   = 8'd1;
                end else if (ld_haz) begin
                    // load completed this cycle; the branch outcome is stale, so no flush
                    hold_if_c = 1'b1;
                    bubble_c  = 1'b1;
                    state_nxt = LD_USE;
                end else begin
                    flush_c = ex_valid & br_taken;
                end
            end
            MEM_WAIT: begin
                req_c = 1'b1;
                if (mem_ack) begin
                    wait_nxt = 8'd0;
                    if (ld_haz) begin
                        hold_if_c = 1'b1;
                        bubble_c  = 1'b1;
                        state_nxt = LD_USE;
                    end else begin
                        state_nxt = RUN;
                    end
                end else begin
                    hold_if_c  = 1'b1;
                    hold_mwb_c = 1'b1;
                    if (wait_cnt == TIMEOUT_TC) begin
                        state_nxt = ERR;
                    end else begin
                        wait_nxt = wait_cnt + 8'd1;
                    end
                end
            end
            LD_USE: begin
                flush_c   = ex_valid & br_taken;
                state_nxt = RUN;
            end
            ERR: begin
                hold_if_c  = 1'b1;
                hold_mwb_c = 1'b1;
                err_c      = 1'b1;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // Outputs are forced low while reset is held, independent of the clock.
    assign mem_req    = rst & req_c;
    assign hold_if    = rst & hold_if_c;
    assign hold_mwb   = rst & hold_mwb_c;
    assign bubble_mwb = rst & bubble_c;
    assign flush_if   = rst & flush_c;
    assign mem_err    = rst & err_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= 16'd0;
        end else if (hold_if && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule
